dual_port_mem_responder: RTL
============================

# dual_port_mem_responder

Synthesizable memory responder for the CPU's split instruction and data ports. It accepts one-cycle imem and dmem request pulses and arbitrates them onto a single-access word array. It returns each request in order with a one-cycle `resp` pulse after a fixed, parameterizable latency. It is the responder end of the CPU memory interface and stands in for the behavioral memory models in FPGA and bring-up builds.

## Interface
- `ADDR_BITS`, default 12: word-index width; array depth is 2^ADDR_BITS 32-bit words.
- `LATENCY`, default 1: cycles from grant to `resp`; legal values are 1 to 15.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `imem_addr`  in  32  instruction byte address.
- `imem_rmask`  in  4  nonzero for one cycle = read request.
- `imem_rdata`  out  32  read word; valid only while `imem_resp`=1.
- `imem_resp`  out  1  one-cycle completion pulse.
- `dmem_addr`  in  32  data byte address.
- `dmem_rmask`  in  4  nonzero for one cycle = read request.
- `dmem_wmask`  in  4  nonzero for one cycle = byte-masked write request.
- `dmem_wdata`  in  32  write data, sampled in the request cycle.
- `dmem_rdata`  out  32  read word; valid only while `dmem_resp`=1.
- `dmem_resp`  out  1  one-cycle completion pulse, for reads and writes.
- `error`  out  1  sticky protocol-violation flag.

## Operation
- Each channel has a request register and a 3-state FSM.
  - IDLE -> PEND on a captured request.
  - PEND -> WAIT when the channel is granted.
  - WAIT counts down LATENCY, then pulses `resp` and returns to IDLE.
- Capture: a request is captured when its mask is nonzero and the channel is IDLE. A channel is also treated as IDLE in its own `resp` cycle, so back-to-back requests are legal.
- Word index is `addr[ADDR_BITS+1:2]`. Upper address bits are ignored, so addresses wrap modulo the array size.
- Arbitration: one array access per cycle. If both channels are in PEND, dmem is granted and imem stays in PEND.
- Read: the full 32-bit word is returned regardless of `rmask`.
- Write: only bytes with `wmask[i]`=1 are updated, committed at the grant edge. `dmem_rdata` holds its previous value on a write `resp`.
- Errors set `error` and it stays set until reset:
  - Request while the channel is PEND or WAIT and not in its `resp` cycle. The new request is dropped.
  - `dmem_rmask` and `dmem_wmask` both nonzero. The request is treated as the write.
  - `addr[1:0]` != 0. The request is still served at the aligned word.
- Reset (async, `rst_n`=0): all outputs are 0, both FSMs go to IDLE, and in-flight requests are discarded with no later `resp`. Array contents are not reset.

## Timing
- The request is sampled at the end of cycle T. The uncontended grant cycle is T+1, and `resp` is asserted in cycle T+1+LATENCY.
- Each cycle a channel spends in PEND without a grant delays its `resp` by one cycle.
- Read-after-write: a write granted in cycle G is visible to any read granted in G+1 or later, on either port.
- Back-to-back dmem traffic leaves at least one free grant cycle between dmem grants, so imem cannot starve.
- `resp` is high for exactly one cycle per accepted request. Responses never reorder within a channel.
- Request pins are ignored while `rst_n`=0. A request is first capturable in the first cycle after `rst_n` is sampled high.

## Test plan
- Single imem read, LATENCY=1, array[0x10>>2]=0xDEADBEEF; request `imem_addr`=0x10, `rmask`=0xF in cycle 5 -> `imem_resp`=1, `imem_rdata`=0xDEADBEEF in cycle 7 only, `error`=0.
- Byte write then read: dmem write addr 0x20, `wmask`=0x3, `wdata`=0xAABBCCDD over old 0x11223344; then dmem read 0x20 in the write's `resp` cycle -> `rdata`=0x1122CCDD two cycles later.
- Simultaneous imem read 0x0 and dmem read 0x4 in cycle 10, LATENCY=2 -> `dmem_resp` in cycle 13, `imem_resp` in cycle 14.
- Protocol errors: imem request while in WAIT -> request dropped, only one `resp`, `error`=1. Separately, dmem `addr`=0x22 read -> word 0x20 returned and `error`=1 held until reset.
- Reset mid-flight: dmem write granted, `rst_n` dropped before `resp` -> all outputs 0 immediately and no `resp` after release. The write is already committed: a read of that address returns the new data.
- Wrap and stress: ADDR_BITS=4, read addr 0x40 -> returns word 0. Then 10k random paired requests (LATENCY 1 to 4) checked against a reference model: no reorder, no lost response, no starvation.

Source files
------------

// File: rtl/dual_port_mem_responder.sv
// dual_port_mem_responder: in-order imem/dmem responder over one single-access word array
// with fixed grant-to-response latency and a sticky protocol-error flag.
module dual_port_mem_responder #(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        error
);
  localparam logic [1:0] IDLE = 2'd0, PEND = 2'd1, WAIT = 2'd2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  logic [31:0] mem [2**ADDR_BITS];
  logic live;
  logic [1:0] i_state, d_state;
  logic [3:0] i_cnt, d_cnt;
  logic [ADDR_BITS-1:0] i_idx, d_idx;
  logic d_wr;
  logic [3:0] d_wmask;
  logic [31:0] d_wdata;
  logic i_req, d_req, i_free, d_free, i_cap, d_cap, i_grant, d_grant, bad;
  logic unused_addr;
  assign unused_addr = ^{imem_addr[31:ADDR_BITS+2], dmem_addr[31:ADDR_BITS+2]};
  // live blocks capture on the first edge that samples rst_n high
  assign i_req = live && |imem_rmask;
  assign d_req = live && (|dmem_rmask || |dmem_wmask);
  assign imem_resp = i_state == WAIT && i_cnt == 4'd0;
  assign dmem_resp = d_state == WAIT && d_cnt == 4'd0;
  assign i_free = i_state == IDLE || imem_resp;
  assign d_free = d_state == IDLE || dmem_resp;
  assign i_cap = i_req && i_free;
  assign d_cap = d_req && d_free;
  assign d_grant = d_state == PEND;
  assign i_grant = i_state == PEND && !d_grant;
  assign bad = (i_req && (!i_free || |imem_addr[1:0])) ||
               (d_req && (!d_free || |dmem_addr[1:0])) ||
               (live && |dmem_rmask && |dmem_wmask);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live       <= 1'b0;
      i_state    <= IDLE;
      d_state    <= IDLE;
      i_cnt      <= 4'd0;
      d_cnt      <= 4'd0;
      i_idx      <= '0;
      d_idx      <= '0;
      d_wr       <= 1'b0;
      d_wmask    <= 4'd0;
      d_wdata    <= 32'd0;
      imem_rdata <= 32'd0;
      dmem_rdata <= 32'd0;
      error      <= 1'b0;
    end else begin
      live    <= 1'b1;
      i_state <= i_cap ? PEND : i_grant ? WAIT : imem_resp ? IDLE : i_state;
      d_state <= d_cap ? PEND : d_grant ? WAIT : dmem_resp ? IDLE : d_state;
      i_cnt   <= i_grant ? LAT_M1 : (i_state == WAIT && i_cnt != 4'd0) ? i_cnt - 4'd1 : i_cnt;
      d_cnt   <= d_grant ? LAT_M1 : (d_state == WAIT && d_cnt != 4'd0) ? d_cnt - 4'd1 : d_cnt;
      if (i_cap) i_idx <= imem_addr[ADDR_BITS+1:2];
      if (d_cap) begin
        d_idx   <= dmem_addr[ADDR_BITS+1:2];
        d_wr    <= |dmem_wmask;
        d_wmask <= dmem_wmask;
        d_wdata <= dmem_wdata;
      end
      if (i_grant) imem_rdata <= mem[i_idx];
      if (d_grant && !d_wr) dmem_rdata <= mem[d_idx];
      error <= error | bad;
    end
  end
  always_ff @(posedge clk) begin
    if (d_grant && d_wr)
      for (int b = 0; b < 4; b++)
        if (d_wmask[b]) mem[d_idx][8*b +: 8] <= d_wdata[8*b +: 8];
  end
endmodule
